bcd_time_chain: RTL and testbench

Parametrised cascade of BCD time digits with a built-in tick divider, per-digit modulus, up/down counting and an atomic preset load. It is the next generation of the fixed 8-digit display counter chain. It sits between the UART preset decoder, which drives `load_valid`/`load_data`, and the per-digit seven-segment decoders, which consume `digits`.

---
 rtl/bcd_time_chain.sv | 121 ++++++++++++
 tb/tb_bcd_time_chain.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_time_chain.sv
// Cascaded BCD time digits with a tick divider, per-digit modulus, up/down count and atomic preset load.
// Digits, tick, wrap and load_err update on the stepping or loading edge. Alarm compare is built only under BCD_CHAIN_ALARM_EN.
module bcd_time_chain #(
  parameter int          NUM_DIGITS = 8,
  parameter int          TICK_DIV   = 25000,
  parameter logic [31:0] DIGIT_MOD  = 32'h6A6A_2AAA
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    run,
  input  logic                    dir,
  input  logic                    load_valid,
  input  logic [4*NUM_DIGITS-1:0] load_data,
  input  logic                    alarm_set,
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic                    tick,
  output logic                    wrap,
  output logic                    load_err,
  output logic                    alarm
);

  localparam int            W        = 4 * NUM_DIGITS;
  localparam int            DW       = $clog2(TICK_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(TICK_DIV - 1);

  logic [DW-1:0]         div_q;
  logic                  step;
  logic [NUM_DIGITS-1:0] dig_en;
  logic [NUM_DIGITS-1:0] dig_max;
  logic [NUM_DIGITS-1:0] dig_zero;
  logic [NUM_DIGITS-1:0] load_bad;
  logic                  chain_out;
  logic [W-1:0]          step_digits;
  logic [W-1:0]          load_clean;

  assign step = run && (div_q == DIV_LAST);

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
    localparam logic [3:0] MOD = DIGIT_MOD[4*i +: 4];
    localparam logic [3:0] TOP = MOD - 4'd1;

    logic [3:0] cur;
    logic [3:0] ld;
    logic [3:0] nxt;

    assign cur         = digits[4*i +: 4];
    assign ld          = load_data[4*i +: 4];
    assign dig_max[i]  = (cur == TOP);
    assign dig_zero[i] = (cur == 4'd0);

    always_comb begin
      nxt = cur;
      if (dig_en[i]) begin
        if (dir) nxt = dig_zero[i] ? TOP : cur - 4'd1;
        else     nxt = dig_max[i] ? 4'd0 : cur + 4'd1;
      end
    end

    assign step_digits[4*i +: 4] = nxt;
    // Out-of-range preset digits are forced to 0 so the chain never holds an illegal code.
    assign load_bad[i]           = (ld >= MOD);
    assign load_clean[4*i +: 4]  = load_bad[i] ? 4'd0 : ld;
  end

  // Ripple enable: a digit moves only when every lower digit is at its roll boundary.
  always_comb begin
    logic c;
    dig_en = '0;
    c      = step;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      dig_en[i] = c;
      c = c && (dir ? dig_zero[i] : dig_max[i]);
    end
    chain_out = c;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q    <= '0;
      digits   <= '0;
      tick     <= 1'b0;
      wrap     <= 1'b0;
      load_err <= 1'b0;
    end else begin
      tick     <= 1'b0;
      wrap     <= 1'b0;
      load_err <= 1'b0;
      if (load_valid) begin
        digits   <= load_clean;
        div_q    <= '0;
        load_err <= |load_bad;
      end else if (step) begin
        digits <= step_digits;
        div_q  <= '0;
        tick   <= 1'b1;
        wrap   <= chain_out;
      end else if (run) begin
        div_q <= div_q + DW'(1);
      end
    end
  end

`ifdef BCD_CHAIN_ALARM_EN
  logic [W-1:0] alarm_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alarm_q <= '0;
      alarm   <= 1'b0;
    end else begin
      if (alarm_set) alarm_q <= load_data;
      alarm <= step && !load_valid && (step_digits == alarm_q);
    end
  end
`else
  logic unused_alarm_set;
  assign unused_alarm_set = alarm_set;
  assign alarm            = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_time_chain.sv
// Bench for bcd_time_chain with TICK_DIV = 4 and the default digit moduli.
module tb_bcd_time_chain;

`ifdef BCD_CHAIN_ALARM_EN
  localparam bit ALARM_ON = 1'b1;
`else
  localparam bit ALARM_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        run = 1'b0;
  logic        dir = 1'b0;
  logic        load_valid = 1'b0;
  logic [31:0] load_data = '0;
  logic        alarm_set = 1'b0;
  logic [31:0] digits;
  logic        tick, wrap, load_err, alarm;

  int tests = 0;
  int fails = 0;
  logic [31:0] alarm_ref = '0;

  typedef struct packed {
    logic [31:0] d;
    logic        t;
    logic        w;
    logic        e;
    logic        a;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic [31:0] ld;
    logic        dr;
    logic [31:0] exp_ld;
    logic        err;
    logic [31:0] exp_st;
    logic        wr;
  } vec_t;
  vec_t vt[12];

  bcd_time_chain #(
    .NUM_DIGITS(8),
    .TICK_DIV  (4),
    .DIGIT_MOD (32'h6A6A_2AAA)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .run       (run),
    .dir       (dir),
    .load_valid(load_valid),
    .load_data (load_data),
    .alarm_set (alarm_set),
    .digits    (digits),
    .tick      (tick),
    .wrap      (wrap),
    .load_err  (load_err),
    .alarm     (alarm)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h required %h", nm, act, exp);
    end
  endtask

  task automatic check_out(input string nm);
    exp_t x;
    if (sb.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL %s: got empty scoreboard required one entry", nm);
      return;
    end
    x = sb.pop_front();
    cmp({nm, ".digits"},   digits,              x.d);
    cmp({nm, ".tick"},     {31'b0, tick},       {31'b0, x.t});
    cmp({nm, ".wrap"},     {31'b0, wrap},       {31'b0, x.w});
    cmp({nm, ".load_err"}, {31'b0, load_err},   {31'b0, x.e});
    cmp({nm, ".alarm"},    {31'b0, alarm},      {31'b0, x.a});
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic push_exp(input logic [31:0] d, input logic t, input logic w, input logic e);
    exp_t x;
    x.d = d;
    x.t = t;
    x.w = w;
    x.e = e;
    x.a = ALARM_ON && t && (d == alarm_ref);
    sb.push_back(x);
  endtask

  task automatic step_chk(input string nm, input logic [31:0] d, input logic t,
                          input logic w, input logic e);
    push_exp(d, t, w, e);
    cyc();
    check_out(nm);
  endtask

  // Three quiet cycles, then the step on the fourth.
  task automatic period(input string nm, input logic [31:0] cur, input logic [31:0] nxt,
                        input logic w);
    for (int k = 0; k < 3; k++) step_chk({nm, ".idle"}, cur, 1'b0, 1'b0, 1'b0);
    step_chk({nm, ".tick"}, nxt, 1'b1, w, 1'b0);
  endtask

  initial begin
    vt[0]  = '{32'h5959_1999, 1'b0, 32'h5959_1999, 1'b0, 32'h0000_0000, 1'b1};
    vt[1]  = '{32'h0000_0000, 1'b1, 32'h0000_0000, 1'b0, 32'h5959_1999, 1'b1};
    vt[2]  = '{32'h0000_0A35, 1'b0, 32'h0000_0035, 1'b1, 32'h0000_0036, 1'b0};
    vt[3]  = '{32'h0000_0009, 1'b0, 32'h0000_0009, 1'b0, 32'h0000_0010, 1'b0};
    vt[4]  = '{32'h0000_1999, 1'b0, 32'h0000_1999, 1'b0, 32'h0001_0000, 1'b0};
    vt[5]  = '{32'h0001_0000, 1'b1, 32'h0001_0000, 1'b0, 32'h0000_1999, 1'b0};
    vt[6]  = '{32'h0005_0959, 1'b0, 32'h0005_0959, 1'b0, 32'h0005_0960, 1'b0};
    vt[7]  = '{32'hFFFF_FFFF, 1'b0, 32'h0000_0000, 1'b1, 32'h0000_0001, 1'b0};
    vt[8]  = '{32'h6A00_0000, 1'b1, 32'h0000_0000, 1'b1, 32'h5959_1999, 1'b1};
    vt[9]  = '{32'h0000_0020, 1'b1, 32'h0000_0020, 1'b0, 32'h0000_0019, 1'b0};
    vt[10] = '{32'h0000_0009, 1'b1, 32'h0000_0009, 1'b0, 32'h0000_0008, 1'b0};
    vt[11] = '{32'h0000_2000, 1'b0, 32'h0000_0000, 1'b1, 32'h0000_0001, 1'b0};

    // Reset values before any clock edge.
    #2 rst = 1'b1;
    #2;
    push_exp(32'h0, 1'b0, 1'b0, 1'b0);
    check_out("reset");
    @(negedge clk);
    @(negedge clk);

    // Release with run=1: ticks on the 4th, 8th, 12th edge.
    rst = 1'b0;
    run = 1'b1;
    dir = 1'b0;
    period("rel1", 32'h0, 32'h1, 1'b0);
    period("rel2", 32'h1, 32'h2, 1'b0);
    period("rel3", 32'h2, 32'h3, 1'b0);

    // Load coinciding with the step condition: load wins, no tick.
    for (int k = 0; k < 3; k++) step_chk("pre_ld", 32'h3, 1'b0, 1'b0, 1'b0);
    load_valid = 1'b1;
    load_data  = 32'h0000_0042;
    step_chk("ld_vs_step", 32'h42, 1'b0, 1'b0, 1'b0);
    load_valid = 1'b0;
    period("after_ld", 32'h42, 32'h43, 1'b0);

    foreach (vt[i]) begin
      dir        = vt[i].dr;
      load_valid = 1'b1;
      load_data  = vt[i].ld;
      step_chk($sformatf("vec%0d.load", i), vt[i].exp_ld, 1'b0, 1'b0, vt[i].err);
      load_valid = 1'b0;
      period($sformatf("vec%0d", i), vt[i].exp_ld, vt[i].exp_st, vt[i].wr);
    end

    // Freeze for 10 cycles mid-period; the remaining two cycles complete afterwards.
    dir = 1'b0;
    step_chk("pre_frz", 32'h1, 1'b0, 1'b0, 1'b0);
    step_chk("pre_frz", 32'h1, 1'b0, 1'b0, 1'b0);
    run = 1'b0;
    for (int k = 0; k < 10; k++) step_chk("frz", 32'h1, 1'b0, 1'b0, 1'b0);
    run = 1'b1;
    step_chk("thaw", 32'h1, 1'b0, 1'b0, 1'b0);
    step_chk("thaw_tick", 32'h2, 1'b1, 1'b0, 1'b0);

    // Load while frozen, then a full period once running.
    run        = 1'b0;
    load_valid = 1'b1;
    load_data  = 32'h0000_0077;
    step_chk("ld_frz", 32'h77, 1'b0, 1'b0, 1'b0);
    load_valid = 1'b0;
    for (int k = 0; k < 3; k++) step_chk("ld_frz_hold", 32'h77, 1'b0, 1'b0, 1'b0);
    run = 1'b1;
    period("ld_frz_run", 32'h77, 32'h78, 1'b0);

    // Asynchronous reset between edges while tick is high.
    #2 rst = 1'b1;
    alarm_ref = '0;
    #1;
    push_exp(32'h0, 1'b0, 1'b0, 1'b0);
    check_out("async_rst");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    period("post_rst", 32'h0, 32'h1, 1'b0);

    // Alarm: set to 3, a matching load stays quiet, counting up fires once.
    alarm_set = 1'b1;
    load_data = 32'h0000_0003;
    if (ALARM_ON) alarm_ref = 32'h0000_0003;
    step_chk("aset", 32'h1, 1'b0, 1'b0, 1'b0);
    alarm_set  = 1'b0;
    load_valid = 1'b1;
    step_chk("aload_match", 32'h3, 1'b0, 1'b0, 1'b0);
    load_data  = 32'h0000_0001;
    step_chk("aload", 32'h1, 1'b0, 1'b0, 1'b0);
    load_valid = 1'b0;
    period("alm1", 32'h1, 32'h2, 1'b0);
    period("alm2", 32'h2, 32'h3, 1'b0);
    period("alm3", 32'h3, 32'h4, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
